// File: rtl/systolic_pkg.sv
// Shared parameters and types for the systolic-array operand feed path.
// Used by the transpose FIFO loader, its bus interface and its testbench.
package systolic_pkg;

    localparam int unsigned DEF_DIM    = 8;
    localparam int unsigned DEF_BITS   = 8;
    localparam int unsigned DEF_ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        STREAM,
        DONE
    } state_e;

    // Element 00 of a row lives at index DIM-1.
    typedef logic [DEF_BITS-1:0] row_t [DEF_DIM-1:0];

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/transpose_fifo_loader_if.sv
// Bus bundle between the loader, the row memory and the transpose FIFO bank.
// master = loader side, slave = memory/FIFO/requester side.
interface transpose_fifo_loader_if
    import systolic_pkg::*;
#(
    parameter int unsigned DIM    = DEF_DIM,
    parameter int unsigned BITS   = DEF_BITS,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;

    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_valid;
    logic [BITS-1:0]   mem_rd_data [DIM-1:0];

    logic [DIM-1:0]    fifo_wr_en;
    logic [BITS-1:0]   fifo_wr_data [DIM-1:0];
    logic [DIM-1:0]    fifo_en;

    modport master (
        input  start,
        input  base_addr,
        input  mem_rd_valid,
        input  mem_rd_data,
        output busy,
        output done,
        output mem_rd_req,
        output mem_addr,
        output fifo_wr_en,
        output fifo_wr_data,
        output fifo_en
    );

    modport slave (
        output start,
        output base_addr,
        output mem_rd_valid,
        output mem_rd_data,
        input  busy,
        input  done,
        input  mem_rd_req,
        input  mem_addr,
        input  fifo_wr_en,
        input  fifo_wr_data,
        input  fifo_en
    );

endinterface

// File: rtl/transpose_fifo_loader_skew_enable_gen.sv
// Diagonal shift-enable pattern: lane i is enabled while i <= cnt < i+DIM.
// Purely combinational so it can also drive de-skew on the array output side.
module skew_enable_gen #(
    parameter int unsigned DIM   = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             active_i,
    output logic [DIM-1:0]   fifo_en_o
);

    always_comb begin
        fifo_en_o = '0;
        for (int unsigned i = 0; i < DIM; i++) begin
            fifo_en_o[i] = active_i
                        && (32'(cnt_i) >= i)
                        && (32'(cnt_i) < i + DIM);
        end
    end

endmodule

// File: rtl/transpose_fifo_loader.sv
// Loads DIM matrix rows from row-wide memory into DIM transpose FIFOs (row r -> FIFO r),
// then streams them out with a one-cycle diagonal skew between neighbouring FIFOs.
module transpose_fifo_loader
    import systolic_pkg::*;
#(
    parameter int unsigned DIM    = DEF_DIM,
    parameter int unsigned BITS   = DEF_BITS,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    transpose_fifo_loader_if.master bus
);

    localparam int unsigned ROW_W  = cnt_width(DIM);
    localparam int unsigned SKEW_W = cnt_width(2 * DIM - 1);

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [SKEW_W-1:0] skew_q, skew_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic last_row;
    logic last_skew;
    logic stream_active;

    assign last_row  = (row_q == ROW_W'(DIM - 1));
    assign last_skew = (skew_q == SKEW_W'(2 * DIM - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            skew_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            skew_q  <= skew_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        skew_d  = skew_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.base_addr;
                    row_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_rd_valid) begin
                    if (last_row) begin
                        skew_d  = '0;
                        state_d = STREAM;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            STREAM: begin
                skew_d = skew_q + 1'b1;
                if (last_skew) begin
                    skew_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write path is combinational from mem_rd_valid so the row lands in the same cycle.
    always_comb begin
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.mem_rd_req = 1'b0;
        bus.mem_addr   = '0;
        bus.fifo_wr_en = '0;
        stream_active  = 1'b0;
        for (int unsigned k = 0; k < DIM; k++) begin
            bus.fifo_wr_data[k] = '0;
        end
        unique case (state_q)
            IDLE: begin
                bus.busy = bus.start;
            end
            REQ: begin
                bus.busy       = 1'b1;
                bus.mem_rd_req = 1'b1;
                bus.mem_addr   = addr_q + ADDR_W'(row_q);
            end
            WAIT: begin
                bus.busy = 1'b1;
                if (bus.mem_rd_valid) begin
                    bus.fifo_wr_en[row_q] = 1'b1;
                    for (int unsigned k = 0; k < DIM; k++) begin
                        bus.fifo_wr_data[k] = bus.mem_rd_data[k];
                    end
                end
            end
            STREAM: begin
                bus.busy      = 1'b1;
                stream_active = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    skew_enable_gen #(
        .DIM   (DIM),
        .CNT_W (SKEW_W)
    ) u_skew (
        .cnt_i     (skew_q),
        .active_i  (stream_active),
        .fifo_en_o (bus.fifo_en)
    );

endmodule

// File: doc/transpose_fifo_loader.md
Name: transpose_fifo_loader

Overview:
- Controller directly upstream of the bank of DIM transpose FIFOs that feed the systolic array.
- On start, fetches DIM matrix rows from a row-wide memory, one row per read.
- Writes row r into FIFO r via a one-hot write enable.
- Then drives per-FIFO shift enables with a one-cycle diagonal skew, so the array receives correctly staggered operands.

Parameters:
- DIM, 8, matrix dimension; number of FIFOs; elements per row; FIFO depth.
- BITS, 8, element width.
- ADDR_W, 8, memory row-address width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- start  input  1  single-cycle request to load and stream one matrix.
- base_addr  input  ADDR_W  row address of matrix row 0; sampled on the accepted start.
- mem_rd_req  output  1  single-cycle read request.
- mem_addr  output  ADDR_W  row address for mem_rd_req.
- mem_rd_valid  input  1  read data valid; arrives 1..N cycles after mem_rd_req.
- mem_rd_data  input  BITS x DIM (unpacked [DIM-1:0])  row data; element 00 is index DIM-1.
- fifo_wr_en  output  DIM  one-hot write enable; bit r drives WrEn of FIFO r.
- fifo_wr_data  output  BITS x DIM (unpacked [DIM-1:0])  row data, broadcast to all FIFOs' Ain.
- fifo_en  output  DIM  shift enable; bit i drives en of FIFO i.
- busy  output  1  high from accepted start until done.
- done  output  1  single-cycle pulse when streaming completes.

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk. Reset is legal mid-operation.
- Reset values: state IDLE; all outputs 0; row counter 0; skew counter 0; address register 0.
- IDLE:
  - start=1 latches base_addr and clears the row counter r.
  - Next cycle: state REQ, busy=1.
  - start in any other state is ignored.
- REQ (exactly 1 cycle):
  - mem_rd_req=1, mem_addr=base_addr+r (mod 2^ADDR_W, wraps silently).
  - Next state WAIT.
- WAIT:
  - Holds until mem_rd_valid=1.
  - In that same cycle, fifo_wr_en = (1<<r) and fifo_wr_data = mem_rd_data, combinationally passed, zero added latency.
  - If r==DIM-1, go to STREAM with skew counter c=0. Otherwise r++ and go to REQ.
- Exactly one outstanding read at a time. mem_rd_valid outside WAIT is ignored: no write occurs.
- fifo_wr_data is 0 whenever fifo_wr_en==0.
- STREAM:
  - fifo_en[i] = 1 iff i <= c < i+DIM. c increments every cycle.
  - When c == 2*DIM-2, the next state is DONE.
  - FIFO 0 shifts in cycles 0..DIM-1; FIFO DIM-1 shifts in cycles DIM-1..2*DIM-2.
  - fifo_wr_en=0 throughout.
- DONE (1 cycle): done=1, busy=0, fifo_en=0; next state IDLE. start is accepted in the following IDLE cycle.
- Latency with fixed read latency L:
  - Load phase: DIM*(1+L) cycles.
  - Stream phase: 2*DIM-1 cycles.
  - Plus 1 start cycle and 1 done cycle.
- Reset in any state: outputs 0 immediately. No partial write or enable is emitted after reset deasserts.

Decomposition:
- Shared package (systolic_pkg): DIM, BITS, ADDR_W defaults; state enum {IDLE, REQ, WAIT, STREAM, DONE}; row_t typedef (unpacked BITS x DIM).
- One natural sub-module: skew_enable_gen. Inputs: c and an active flag. Output: fifo_en[DIM-1:0]. Purely combinational compare, reusable on the output side of the array for de-skew.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with start=0 for 10 cycles -> all outputs 0, busy=0.
- Basic load, L=1, DIM=8, base_addr=0x10, row r elements = r*8+k:
  - mem_addr sequence 0x10..0x17.
  - fifo_wr_en sequence 0x01,0x02,..,0x80, each with matching data.
  - busy high 8*2+15+1 cycles.
  - done pulses exactly once.
- Skew, with real transpose FIFOs attached:
  - In STREAM cycle c, fifo_en == ((1<<(c+1))-1) & ~((1<<(c-7))-1) clipped to 8 bits. For example, c=0 -> 0x01, c=7 -> 0xFF, c=14 -> 0x80.
  - FIFO outputs form the expected diagonal.
- Variable latency: mem_rd_valid delayed 1,5,3,.. cycles; inject a spurious mem_rd_valid during REQ -> exactly 8 writes in row order, spurious valid ignored.
- Wrap and ignore:
  - base_addr=0xFC -> addresses 0xFC,0xFD,0xFE,0xFF,0x00..0x03.
  - start pulsed mid-STREAM -> no restart; done count stays 1.
- Reset mid-op: assert rst_n=0 in WAIT of row 4 -> all outputs 0 next edge. A fresh start then completes a full 8-row load from row 0.
